prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Receives a program image over an 8-bit valid/ready byte stream
//            and writes it into instruction memory while halting the CPU.
//            Stream format: 1 header byte (word count N, 0 => full memory),
//            N words of DATA_WIDTH/8 bytes each (MSB first), then one
//            XOR checksum byte covering every data byte.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            start              - one-cycle load request (IDLE/DONE/ERROR)
//            rx_data/rx_valid   - incoming byte stream
//            rx_ready           - loader can accept a byte this cycle
//            mem_addr/mem_data  - instruction memory write address / word
//            mem_we             - one-cycle write strobe
//            cpu_halt, busy     - load in progress
//            done, error        - result of the last load, held
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  cpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int c_BPW = DATA_WIDTH / 8;
    localparam int c_BCW = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    // Word counters must hold both the 8-bit header value and 2**ADDR_WIDTH.
    localparam int c_CW  = (ADDR_WIDTH + 1 > 9) ? ADDR_WIDTH + 1 : 9;

    localparam logic [c_CW-1:0]  c_CAP       = c_CW'(1) << ADDR_WIDTH;
    localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(c_BPW - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [c_CW-1:0]       r_count;
    logic [c_CW-1:0]       r_words;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_word;
    logic [c_BCW-1:0]      r_byte_cnt;
    logic [7:0]            r_csum;

    logic                  w_fire;
    logic [c_CW-1:0]       w_hdr_n;
    logic                  w_last_word;

    assign rx_ready = (r_state == S_HEADER) || (r_state == S_LOAD) ||
                      (r_state == S_CHECK);
    assign mem_we   = (r_state == S_WRITE);
    assign busy     = (r_state == S_HEADER) || (r_state == S_LOAD) ||
                      (r_state == S_WRITE)  || (r_state == S_CHECK);
    assign cpu_halt = busy;
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERROR);
    assign mem_addr = r_addr;
    assign mem_data = r_word;

    assign w_fire      = rx_valid && rx_ready;
    // A zero header byte encodes a full-memory load.
    assign w_hdr_n     = (rx_data == 8'd0) ? c_CAP : c_CW'(rx_data);
    assign w_last_word = ((r_words + c_CW'(1)) == r_count);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_next = S_HEADER;
            end
            S_HEADER: begin
                if (w_fire) w_next = (w_hdr_n > c_CAP) ? S_ERROR : S_LOAD;
            end
            S_LOAD: begin
                if (w_fire && (r_byte_cnt == c_LAST_BYTE)) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_next = w_last_word ? S_CHECK : S_LOAD;
            end
            S_CHECK: begin
                if (w_fire) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_words    <= '0;
            r_addr     <= '0;
            r_word     <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_count    <= '0;
                        r_words    <= '0;
                        r_addr     <= '0;
                        r_byte_cnt <= '0;
                        r_csum     <= '0;
                    end
                end
                S_HEADER: begin
                    if (w_fire) r_count <= w_hdr_n;
                end
                S_LOAD: begin
                    if (w_fire) begin
                        r_word     <= (r_word << 8) | DATA_WIDTH'(rx_data);
                        r_csum     <= r_csum ^ rx_data;
                        r_byte_cnt <= (r_byte_cnt == c_LAST_BYTE) ? '0
                                                                  : r_byte_cnt + c_BCW'(1);
                    end
                end
                S_WRITE: begin
                    r_words <= r_words + c_CW'(1);
                    // Holding the address on the final word keeps a
                    // full-memory load from wrapping back to 0.
                    if (!w_last_word) r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Directed self-checking bench for prog_loader (32-bit words,
//            64-word memory).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0]  q_addr[$];
    logic [31:0] q_data[$];

    prog_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte and return just after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                ok = 1'b1;
                tick();
                break;
            end
        end
        rx_valid = 1'b0;
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        logic [7:0]  bytes[$];
        logic [7:0]  csum;
        logic [31:0] w;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_rx_ready", rx_ready, 0);
        check("rst_mem_we",   mem_we,   0);
        check("rst_cpu_halt", cpu_halt, 0);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_error",    error,    0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);

        // Single word, good checksum
        clear_log();
        do_start();
        check("hdr_busy",     busy,     1);
        check("hdr_cpu_halt", cpu_halt, 1);
        check("hdr_rx_ready", rx_ready, 1);
        bytes = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        foreach (bytes[i]) send_byte(bytes[i]);
        check("one_nwrites", q_addr.size(), 1);
        if (q_addr.size() >= 1) begin
            check("one_addr", q_addr[0], 0);
            check("one_data", q_data[0], 32'h12345678);
        end
        check("one_done",     done,     1);
        check("one_error",    error,    0);
        check("one_cpu_halt", cpu_halt, 0);
        check("one_busy",     busy,     0);
        // A byte offered in DONE must not be taken
        rx_data = 8'hAA; rx_valid = 1'b1;
        #1;
        check("done_rx_ready", rx_ready, 0);
        tick();
        rx_valid = 1'b0;
        check("done_held", done, 1);

        // Two words
        clear_log();
        do_start();
        check("two_done_cleared", done, 0);
        bytes = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23};
        foreach (bytes[i]) send_byte(bytes[i]);
        check("two_nwrites", q_addr.size(), 2);
        if (q_addr.size() >= 2) begin
            check("two_addr0", q_addr[0], 0);
            check("two_data0", q_data[0], 32'hDEADBEEF);
            check("two_addr1", q_addr[1], 1);
            check("two_data1", q_data[1], 32'h00000001);
        end
        check("two_done", done, 1);

        // Bad checksum: the write stays, load ends in error
        clear_log();
        do_start();
        bytes = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        foreach (bytes[i]) send_byte(bytes[i]);
        check("bad_nwrites", q_addr.size(), 1);
        if (q_data.size() >= 1) check("bad_data", q_data[0], 32'h12345678);
        check("bad_error", error, 1);
        check("bad_done",  done,  0);

        // Oversized header
        clear_log();
        do_start();
        check("big_error_cleared", error, 0);
        send_byte(8'h41);
        check("big_error",   error, 1);
        check("big_busy",    busy,  0);
        check("big_nwrites", q_addr.size(), 0);

        // Full memory (N=0) with a gap cycle after every byte
        clear_log();
        do_start();
        send_byte(8'h00);
        csum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'((i * 37 + 11) ^ (i >> 3));
            csum ^= b;
            send_byte(b);
            tick();
        end
        send_byte(csum);
        check("full_nwrites", q_addr.size(), 64);
        for (int k = 0; k < 64 && k < q_addr.size(); k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                int i;
                i = 4 * k + j;
                w = {w[23:0], 8'((i * 37 + 11) ^ (i >> 3))};
            end
            check($sformatf("full_addr%0d", k), q_addr[k], k);
            check($sformatf("full_data%0d", k), q_data[k], w);
        end
        check("full_done", done, 1);

        // Reset mid-load dominates start and rx_valid
        clear_log();
        do_start();
        send_byte(8'h01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hEF;
        tick();
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
        check("mid_rx_ready", rx_ready, 0);
        check("mid_mem_we",   mem_we,   0);
        check("mid_cpu_halt", cpu_halt, 0);
        check("mid_busy",     busy,     0);
        check("mid_done",     done,     0);
        check("mid_error",    error,    0);
        check("mid_mem_addr", mem_addr, 0);
        check("mid_mem_data", mem_data, 0);
        tick(); tick();
        check("mid_nwrites", q_addr.size(), 0);
        do_start();
        bytes = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        foreach (bytes[i]) send_byte(bytes[i]);
        check("after_nwrites", q_addr.size(), 1);
        if (q_data.size() >= 1) check("after_data", q_data[0], 32'h12345678);
        check("after_done", done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
